// File: rtl/apb_pkg.sv
// Shared state encoding and default bus widths for the round-robin APB master.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin grant: first set request searching upward from ptr+1 (mod NUM_REQ).
// Latency: combinational.
// Backpressure: none; the caller decides when a grant is taken.
module apb_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!gnt_vld && req[cand]) begin
                gnt_vld   = 1'b1;
                gnt_idx   = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// Shares one APB slave between NUM_REQ requesters (round-robin); APB_TIMEOUT_EN adds an ACCESS timeout.
// Latency: grant cycle + SETUP + ACCESS (>=1), completion pulse registered one cycle after PREADY.
// Backpressure: requesters hold req_valid/payload until rsp_done; slave stalls via _PREADY.
module apb_rr_master
    import apb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      _PCLK,
    input  logic                      _PRESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_done,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_slverr,
    output logic                      _PSEL1,
    output logic                      _PENABLE,
    output logic                      _PWRITE,
    output logic [ADDR_W-1:0]         _PADDR,
    output logic [DATA_W-1:0]         _PWDATA,
    input  logic [DATA_W-1:0]         _PRDATA,
    input  logic                      _PREADY,
    input  logic                      _PSLVERR
);

    localparam int IDX_W = $clog2(NUM_REQ);

    apb_state_t         state_q, state_nxt;
    logic [IDX_W-1:0]   ptr_q, ptr_nxt;
    logic [NUM_REQ-1:0] grant_q, grant_nxt;
    logic               psel_nxt, penable_nxt, pwrite_nxt, slverr_nxt;
    logic [ADDR_W-1:0]  paddr_nxt;
    logic [DATA_W-1:0]  pwdata_nxt, rdata_nxt;
    logic [NUM_REQ-1:0] done_nxt;

    logic [NUM_REQ-1:0] arb_req, arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_vld;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    // The requester just completed still shows req_valid during its rsp_done cycle.
    assign arb_req = req_valid & ~rsp_done;

    apb_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req     (arb_req),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge _PCLK or posedge _PRESET) begin
        if (_PRESET) begin
            state_q    <= IDLE;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
            grant_q    <= '0;
            _PSEL1     <= 1'b0;
            _PENABLE   <= 1'b0;
            _PWRITE    <= 1'b0;
            _PADDR     <= '0;
            _PWDATA    <= '0;
            rsp_done   <= '0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_nxt;
            ptr_q      <= ptr_nxt;
            grant_q    <= grant_nxt;
            _PSEL1     <= psel_nxt;
            _PENABLE   <= penable_nxt;
            _PWRITE    <= pwrite_nxt;
            _PADDR     <= paddr_nxt;
            _PWDATA    <= pwdata_nxt;
            rsp_done   <= done_nxt;
            rsp_rdata  <= rdata_nxt;
            rsp_slverr <= slverr_nxt;
`ifdef APB_TIMEOUT_EN
            cnt_q      <= cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state_q;
        ptr_nxt     = ptr_q;
        grant_nxt   = grant_q;
        psel_nxt    = _PSEL1;
        penable_nxt = _PENABLE;
        pwrite_nxt  = _PWRITE;
        paddr_nxt   = _PADDR;
        pwdata_nxt  = _PWDATA;
        done_nxt    = '0;
        rdata_nxt   = rsp_rdata;
        slverr_nxt  = rsp_slverr;
`ifdef APB_TIMEOUT_EN
        cnt_nxt     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
                if (arb_vld) begin
                    state_nxt  = SETUP;
                    ptr_nxt    = arb_idx;
                    grant_nxt  = arb_gnt;
                    psel_nxt   = 1'b1;
                    pwrite_nxt = req_write[arb_idx];
                    paddr_nxt  = addr_arr[arb_idx];
                    pwdata_nxt = wdata_arr[arb_idx];
                end
            end
            SETUP: begin
                state_nxt   = ACCESS;
                penable_nxt = 1'b1;
`ifdef APB_TIMEOUT_EN
                cnt_nxt     = '0;
`endif
            end
            ACCESS: begin
                if (_PREADY) begin
                    state_nxt   = IDLE;
                    psel_nxt    = 1'b0;
                    penable_nxt = 1'b0;
                    done_nxt    = grant_q;
                    rdata_nxt   = _PWRITE ? '0 : _PRDATA;
                    slverr_nxt  = _PSLVERR;
                end
`ifdef APB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt   = IDLE;
                    psel_nxt    = 1'b0;
                    penable_nxt = 1'b0;
                    done_nxt    = grant_q;
                    rdata_nxt   = '0;
                    slverr_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_nxt   = IDLE;
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
            end
        endcase
    end

endmodule
